// File: rtl/pipe_cmp_driver.sv
// pipe_cmp_driver: drives LFSR-generated operand vectors into an external
// 3-stage compare pipeline and checks the returned mismatch flag against a
// locally computed expectation delayed by the pipeline latency.
module pipe_cmp_driver #(
  parameter int          NUM_VEC = 16,
  parameter logic [31:0] SEED    = 32'hACE1_2468
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [7:0] C,
  output logic [7:0] D,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] err_cnt,
  output logic [7:0] ones_cnt,
  output logic [7:0] first_err_idx
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [7:0]  LAST_IDX = 8'(NUM_VEC - 1);
  // Vector indices never exceed 254, so 8'hFF safely means "no error yet".
  localparam logic [7:0]  NO_ERR   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [31:0]     lfsr;
  logic [31:0]     lfsr_next;
  logic [7:0]      vec_idx;
  logic [7:0]      vec_idx_next;
  logic [3:0]      dl_valid;
  logic [3:0]      dl_exp;
  logic [3:0][7:0] dl_idx;
  logic            exp_seed;
  logic            exp_next;
  logic            cmp_valid;
  logic            cmp_mis;
  logic            final_cmp;

  // Reference function of the compare pipeline for one packed {A,B,C,D} vector.
  function automatic logic expect_of(input logic [31:0] v);
    logic [7:0] a, b, c, d;
    a = v[31:24];
    b = v[23:16];
    c = v[15:8];
    d = v[7:0];
    return (((b & c) ^ d) != (a | b));
  endfunction

  // Next LFSR state and the expectations for the vectors about to be launched.
  always_comb begin
    lfsr_next    = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
    vec_idx_next = vec_idx + 8'd1;
    exp_seed     = expect_of(SEED_EFF);
    exp_next     = expect_of(lfsr_next);
  end

  // The oldest delay-line slot lines up with the dut_out sample for its vector.
  always_comb begin
    cmp_valid = dl_valid[3];
    cmp_mis   = dl_valid[3] && (dl_exp[3] != dut_out);
    final_cmp = dl_valid[3] && (dl_idx[3] == LAST_IDX);
  end

  // Control FSM, vector launch register, delay line and result counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= SEED_EFF;
      vec_idx       <= 8'd0;
      A             <= 8'd0;
      B             <= 8'd0;
      C             <= 8'd0;
      D             <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= 8'd0;
      ones_cnt      <= 8'd0;
      first_err_idx <= NO_ERR;
      dl_valid      <= 4'd0;
      dl_exp        <= 4'd0;
      dl_idx        <= '0;
    end else begin
      dl_valid <= {dl_valid[2:0], 1'b0};
      dl_exp   <= {dl_exp[2:0], 1'b0};
      dl_idx   <= {dl_idx[2:0], 8'd0};

      if (cmp_valid) begin
        if (cmp_mis) begin
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
          if (first_err_idx == NO_ERR) begin
            first_err_idx <= dl_idx[3];
          end
        end
        if (dut_out) begin
          ones_cnt <= ones_cnt + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state         <= (LAST_IDX == 8'd0) ? DRAIN : DRIVE;
            busy          <= 1'b1;
            lfsr          <= SEED_EFF;
            vec_idx       <= 8'd0;
            {A, B, C, D}  <= SEED_EFF;
            err_cnt       <= 8'd0;
            ones_cnt      <= 8'd0;
            first_err_idx <= NO_ERR;
            dl_valid      <= 4'b0001;
            dl_exp        <= {3'b000, exp_seed};
            dl_idx        <= '0;
          end
        end
        DRIVE: begin
          lfsr         <= lfsr_next;
          vec_idx      <= vec_idx_next;
          {A, B, C, D} <= lfsr_next;
          dl_valid     <= {dl_valid[2:0], 1'b1};
          dl_exp       <= {dl_exp[2:0], exp_next};
          dl_idx       <= {dl_idx[2:0], vec_idx_next};
          if (vec_idx_next == LAST_IDX) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          {A, B, C, D} <= 32'd0;
          if (final_cmp) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_cmp_driver.sv
// Directed bench for pipe_cmp_driver: a behavioural 3-stage compare pipeline
// closes the loop, with optional inversion and a single-slot flip.
module tb_pipe_cmp_driver;

  localparam int          NV   = 16;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B, C, D;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic [7:0] err_cnt, ones_cnt, first_err_idx;

  logic invert = 1'b0;
  logic flip   = 1'b0;
  logic r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] vecs[NV];
  logic        expb[NV];
  int          expSum;

  pipe_cmp_driver #(.NUM_VEC(NV), .SEED(SEED)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .A             (A),
    .B             (B),
    .C             (C),
    .D             (D),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .err_cnt       (err_cnt),
    .ones_cnt      (ones_cnt),
    .first_err_idx (first_err_idx)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural compare pipeline: three registers after the launch register.
  always @(posedge clk) begin
    r1 <= (((B & C) ^ D) != (A | B));
    r2 <= r1;
    r3 <= r2;
  end

  assign dut_out = r3 ^ invert ^ flip;

  function automatic logic [31:0] lfsrNext(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: mode 0 = straight loopback, 1 = inverted; flipIdx >= 0 flips that slot.
  task automatic applyStimulus(input int mode, input int flipIdx, input bit pulseStart);
    int expErr, expOnes, expFirst, doneSeen;
    expErr   = 0;
    expOnes  = expSum;
    expFirst = 255;
    if (mode == 1) begin
      expErr   = NV;
      expOnes  = NV - expSum;
      expFirst = 0;
    end else if (flipIdx >= 0) begin
      expErr   = 1;
      expFirst = flipIdx;
      expOnes  = expSum + (expb[flipIdx] ? -1 : 1);
    end
    invert   = (mode == 1);
    doneSeen = 0;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("vec0_hand", {A, B, C, D}, 32'hACE1_2468);
    checkOutput("busy_start", busy, 1'b1);
    checkOutput("done_start", done, 1'b0);

    for (int k = 1; k <= NV + 3; k++) begin
      start = pulseStart && (k == 3);
      flip  = (k == flipIdx + 4);
      @(posedge clk);
      #1;
      start = 1'b0;
      flip  = 1'b0;
      if (done) doneSeen++;
      if (k == 1) checkOutput("vec1_hand", {A, B, C, D}, 32'h5670_9234);
      checkOutput($sformatf("vec%0d", k), {A, B, C, D}, (k < NV) ? vecs[k] : 32'd0);
      checkOutput($sformatf("busy%0d", k), busy, (k <= NV + 2));
      checkOutput($sformatf("done%0d", k), done, (k == NV + 3));
    end

    checkOutput("err_cnt", err_cnt, expErr);
    checkOutput("ones_cnt", ones_cnt, expOnes);
    checkOutput("first_err_idx", first_err_idx, expFirst);

    start = pulseStart;
    @(posedge clk);
    #1 start = 1'b0;
    if (done) doneSeen++;
    checkOutput("done_after", done, 1'b0);
    checkOutput("busy_after", busy, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("busy_idle", busy, 1'b0);
    checkOutput("done_pulses", doneSeen, 1);
    checkOutput("err_hold", err_cnt, expErr);
    checkOutput("ones_hold", ones_cnt, expOnes);
    checkOutput("first_hold", first_err_idx, expFirst);
    invert = 1'b0;
  endtask

  initial begin
    logic [31:0] l;
    int doneCount;
    l      = SEED;
    expSum = 0;
    for (int i = 0; i < NV; i++) begin
      vecs[i] = l;
      expb[i] = (((l[23:16] & l[15:8]) ^ l[7:0]) != (l[31:24] | l[23:16]));
      expSum += int'(expb[i]);
      l = lfsrNext(l);
    end

    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_abcd", {A, B, C, D}, 32'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err_cnt, 8'd0);
    checkOutput("rst_ones", ones_cnt, 8'd0);
    checkOutput("rst_first", first_err_idx, 8'hFF);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] loopback run");
    applyStimulus(0, -1, 1'b0);
    $display("[TB] inverted run");
    applyStimulus(1, -1, 1'b0);
    $display("[TB] flip vector 5 run with ignored start pulses");
    applyStimulus(0, 5, 1'b1);

    $display("[TB] reset while vector 7 launches");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("mid_abcd", {A, B, C, D}, 32'd0);
    checkOutput("mid_busy", busy, 1'b0);
    checkOutput("mid_done", done, 1'b0);
    checkOutput("mid_err", err_cnt, 8'd0);
    checkOutput("mid_ones", ones_cnt, 8'd0);
    checkOutput("mid_first", first_err_idx, 8'hFF);
    doneCount = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("mid_no_done", doneCount, 0);
    checkOutput("mid_busy_end", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
